// File: rtl/reg_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter_if
// Bus bundle between the register-access arbiter, its two requesters (A: I2C
// slave engine, B: local host bus) and the 8-entry register file port.
//   Requester A/B : xReq, xWe, xAddr, xWdata  -> arbiter
//                   xGnt, xRvalid, xRdata, xErr <- arbiter
//   Register file : regAddr, regDataIn, regWriteEn <- arbiter
//                   regDataOut                     -> arbiter
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters + register file)
// -----------------------------------------------------------------------------
interface reg_access_arbiter_if;
   logic       aReq;
   logic       aWe;
   logic [7:0] aAddr;
   logic [7:0] aWdata;
   logic       aGnt;
   logic       aRvalid;
   logic [7:0] aRdata;
   logic       aErr;

   logic       bReq;
   logic       bWe;
   logic [7:0] bAddr;
   logic [7:0] bWdata;
   logic       bGnt;
   logic       bRvalid;
   logic [7:0] bRdata;
   logic       bErr;

   logic [7:0] regAddr;
   logic [7:0] regDataIn;
   logic       regWriteEn;
   logic [7:0] regDataOut;

   modport slave (
      input  aReq, aWe, aAddr, aWdata,
      output aGnt, aRvalid, aRdata, aErr,
      input  bReq, bWe, bAddr, bWdata,
      output bGnt, bRvalid, bRdata, bErr,
      output regAddr, regDataIn, regWriteEn,
      input  regDataOut
   );

   modport master (
      output aReq, aWe, aAddr, aWdata,
      input  aGnt, aRvalid, aRdata, aErr,
      output bReq, bWe, bAddr, bWdata,
      input  bGnt, bRvalid, bRdata, bErr,
      input  regAddr, regDataIn, regWriteEn,
      output regDataOut
   );
endinterface

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
// Two-requester arbiter in front of the I2C slave register file. One access is
// in flight at a time: a write occupies WRITE for one cycle, a read walks
// RD_ADDR -> RD_CAPT to cover the file's one-cycle read latency. Writes to
// read-only or unmapped addresses are dropped and flagged on xErr.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - reg_access_arbiter_if.slave (requester A/B and register file port)
// Parameters:
//   RW_REGS    - addresses 0..RW_REGS-1 are writable
//   NUM_REGS   - addresses >= NUM_REGS are unmapped (read as 8'h00)
//   A_PRIORITY - 1: A wins ties, 0: round-robin on ties
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
   parameter int RW_REGS    = 4,
   parameter int NUM_REGS   = 8,
   parameter int A_PRIORITY = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   reg_access_arbiter_if.slave  bus
);

   localparam logic [7:0] RW_LIMIT  = 8'(RW_REGS);
   localparam logic [7:0] MAP_LIMIT = 8'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_CAPT} state_t;

   state_t     r_state;
   logic       r_owner;      // 0 = A, 1 = B
   logic       r_we;
   logic [7:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_wr_blk;
   logic       r_ptr;        // round-robin pointer, 0 = A
   logic       r_rd_pend;    // read data captured, rvalid due next cycle

   logic       r_a_gnt, r_a_rvalid, r_a_err;
   logic       r_b_gnt, r_b_rvalid, r_b_err;
   logic [7:0] r_a_rdata, r_b_rdata;
   logic [7:0] r_reg_addr, r_reg_wdata;
   logic       r_reg_we;

   logic       w_req_any;
   logic       w_pick_b;
   logic       w_we;
   logic [7:0] w_addr;
   logic [7:0] w_wdata;
   logic       w_wr_ok;

   // B wins when alone, or on a tie when round-robin is active and the pointer is at B
   assign w_req_any = bus.aReq | bus.bReq;
   assign w_pick_b  = bus.bReq & (~bus.aReq | (r_ptr & (A_PRIORITY == 0)));
   assign w_we      = w_pick_b ? bus.bWe    : bus.aWe;
   assign w_addr    = w_pick_b ? bus.bAddr  : bus.aAddr;
   assign w_wdata   = w_pick_b ? bus.bWdata : bus.aWdata;
   assign w_wr_ok   = (w_addr < RW_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 8'h00;
         r_wdata     <= 8'h00;
         r_wr_blk    <= 1'b0;
         r_ptr       <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_a_gnt     <= 1'b0;
         r_a_rvalid  <= 1'b0;
         r_a_err     <= 1'b0;
         r_a_rdata   <= 8'h00;
         r_b_gnt     <= 1'b0;
         r_b_rvalid  <= 1'b0;
         r_b_err     <= 1'b0;
         r_b_rdata   <= 8'h00;
         r_reg_addr  <= 8'h00;
         r_reg_wdata <= 8'h00;
         r_reg_we    <= 1'b0;
      end else begin
         r_a_gnt    <= 1'b0;
         r_b_gnt    <= 1'b0;
         r_a_err    <= 1'b0;
         r_b_err    <= 1'b0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_reg_we   <= 1'b0;

         case (r_state)
            IDLE: begin
               // rvalid of the previous read can coincide with a new grant;
               // r_owner still holds the previous owner here
               if (r_rd_pend) begin
                  r_rd_pend <= 1'b0;
                  if (r_owner) r_b_rvalid <= 1'b1;
                  else         r_a_rvalid <= 1'b1;
               end
               if (w_req_any) begin
                  r_owner <= w_pick_b;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  if (w_pick_b) r_b_gnt <= 1'b1;
                  else          r_a_gnt <= 1'b1;
                  if (bus.aReq && bus.bReq && (A_PRIORITY == 0))
                     r_ptr <= ~r_ptr;
                  if (w_we) begin
                     // block decision and err are registered with gnt
                     r_wr_blk <= ~w_wr_ok;
                     if (!w_wr_ok) begin
                        if (w_pick_b) r_b_err <= 1'b1;
                        else          r_a_err <= 1'b1;
                     end
                     r_state <= WRITE;
                  end else begin
                     // present the read address during RD_ADDR so the file's
                     // registered output is ready in RD_CAPT
                     r_reg_addr <= w_addr;
                     r_state    <= RD_ADDR;
                  end
               end
            end
            WRITE: begin
               if (!r_wr_blk) begin
                  r_reg_we    <= 1'b1;
                  r_reg_addr  <= r_addr;
                  r_reg_wdata <= r_wdata;
               end
               r_state <= IDLE;
            end
            RD_ADDR: begin
               r_state <= RD_CAPT;
            end
            RD_CAPT: begin
               if (r_owner) r_b_rdata <= (r_addr < MAP_LIMIT) ? bus.regDataOut : 8'h00;
               else         r_a_rdata <= (r_addr < MAP_LIMIT) ? bus.regDataOut : 8'h00;
               r_rd_pend <= 1'b1;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.aGnt       = r_a_gnt;
   assign bus.aRvalid    = r_a_rvalid;
   assign bus.aRdata     = r_a_rdata;
   assign bus.aErr       = r_a_err;
   assign bus.bGnt       = r_b_gnt;
   assign bus.bRvalid    = r_b_rvalid;
   assign bus.bRdata     = r_b_rdata;
   assign bus.bErr       = r_b_err;
   assign bus.regAddr    = r_reg_addr;
   assign bus.regDataIn  = r_reg_wdata;
   assign bus.regWriteEn = r_reg_we;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
// Directed bench for reg_access_arbiter (round-robin build, A_PRIORITY=0) with
// a small register file model: regs 0..3 writable, regs 4..7 fixed inputs
// (reg5 = 8'h3C), registered read data.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   reg_access_arbiter_if bus_if ();

   reg_access_arbiter #(
      .RW_REGS    (4),
      .NUM_REGS   (8),
      .A_PRIORITY (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file model
   logic [7:0] mem [4] = '{default: 8'h00};

   function automatic logic [7:0] rf_read(input logic [7:0] a, input logic [7:0] m0,
                                          input logic [7:0] m1, input logic [7:0] m2,
                                          input logic [7:0] m3);
      case (a)
         8'd0:    return m0;
         8'd1:    return m1;
         8'd2:    return m2;
         8'd3:    return m3;
         8'd4:    return 8'hA4;
         8'd5:    return 8'h3C;
         8'd6:    return 8'hA6;
         8'd7:    return 8'hA7;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus_if.regWriteEn && (bus_if.regAddr < 8'd4))
         mem[bus_if.regAddr[1:0]] <= bus_if.regDataIn;
      bus_if.regDataOut <= rf_read(bus_if.regAddr, mem[0], mem[1], mem[2], mem[3]);
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit side, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata);
      if (side) begin
         bus_if.bReq = 1'b1; bus_if.bWe = we; bus_if.bAddr = addr; bus_if.bWdata = wdata;
      end else begin
         bus_if.aReq = 1'b1; bus_if.aWe = we; bus_if.aAddr = addr; bus_if.aWdata = wdata;
      end
   endtask

   task automatic drop_req(input bit side);
      if (side) bus_if.bReq = 1'b0;
      else      bus_if.aReq = 1'b0;
   endtask

   // single write: gnt/err in grant cycle, strobe in the next
   task automatic write_chk(input bit side, input logic [7:0] addr, input logic [7:0] data,
                            input bit blocked, input string tag);
      set_req(side, 1'b1, addr, data);
      tick();
      check_val({tag, "_gnt"}, side ? bus_if.bGnt : bus_if.aGnt, 8'd1);
      check_val({tag, "_err"}, side ? bus_if.bErr : bus_if.aErr, {7'd0, blocked});
      check_val({tag, "_we_g"}, bus_if.regWriteEn, 8'd0);
      drop_req(side);
      tick();
      check_val({tag, "_we"}, bus_if.regWriteEn, {7'd0, !blocked});
      if (!blocked) begin
         check_val({tag, "_addr"}, bus_if.regAddr, addr);
         check_val({tag, "_wdata"}, bus_if.regDataIn, data);
      end
   endtask

   // single read: rvalid and data at gnt+3
   task automatic read_chk(input bit side, input logic [7:0] addr, input logic [7:0] exp,
                           input string tag);
      set_req(side, 1'b0, addr, 8'h00);
      tick();
      check_val({tag, "_gnt"}, side ? bus_if.bGnt : bus_if.aGnt, 8'd1);
      check_val({tag, "_err"}, side ? bus_if.bErr : bus_if.aErr, 8'd0);
      drop_req(side);
      tick();
      tick();
      check_val({tag, "_rv_early"}, side ? bus_if.bRvalid : bus_if.aRvalid, 8'd0);
      tick();
      check_val({tag, "_rvalid"}, side ? bus_if.bRvalid : bus_if.aRvalid, 8'd1);
      check_val({tag, "_rdata"}, side ? bus_if.bRdata : bus_if.aRdata, exp);
   endtask

   initial begin
      logic [7:0] exp_b2b [4];
      bit         seen_rv;
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus_if.aReq = 1'b0; bus_if.aWe = 1'b0; bus_if.aAddr = 8'h00; bus_if.aWdata = 8'h00;
      bus_if.bReq = 1'b0; bus_if.bWe = 1'b0; bus_if.bAddr = 8'h00; bus_if.bWdata = 8'h00;
      tick();
      tick();
      check_val("rst_agnt", bus_if.aGnt, 8'd0);
      check_val("rst_bgnt", bus_if.bGnt, 8'd0);
      check_val("rst_we", bus_if.regWriteEn, 8'd0);
      check_val("rst_regaddr", bus_if.regAddr, 8'h00);
      check_val("rst_arvalid", bus_if.aRvalid, 8'd0);
      check_val("rst_ardata", bus_if.aRdata, 8'h00);
      check_val("rst_brdata", bus_if.bRdata, 8'h00);
      rst_n = 1'b1;
      tick();

      // 1: write then read back
      write_chk(1'b0, 8'd1, 8'h5A, 1'b0, "t1_wr");
      read_chk(1'b0, 8'd1, 8'h5A, "t1_rd");

      // 2: ties under round-robin
      set_req(1'b0, 1'b1, 8'd0, 8'h11);
      set_req(1'b1, 1'b1, 8'd2, 8'h22);
      tick();
      check_val("t2a_agnt", bus_if.aGnt, 8'd1);
      check_val("t2a_bgnt", bus_if.bGnt, 8'd0);
      drop_req(1'b0);
      tick();
      check_val("t2a_we_a", bus_if.regWriteEn, 8'd1);
      check_val("t2a_addr_a", bus_if.regAddr, 8'd0);
      check_val("t2a_bgnt1", bus_if.bGnt, 8'd0);
      tick();
      check_val("t2a_bgnt2", bus_if.bGnt, 8'd1);
      drop_req(1'b1);
      tick();
      check_val("t2a_addr_b", bus_if.regAddr, 8'd2);
      set_req(1'b0, 1'b1, 8'd0, 8'h11);
      set_req(1'b1, 1'b1, 8'd2, 8'h22);
      tick();
      check_val("t2b_bgnt", bus_if.bGnt, 8'd1);
      check_val("t2b_agnt", bus_if.aGnt, 8'd0);
      drop_req(1'b1);
      tick();
      tick();
      check_val("t2b_agnt2", bus_if.aGnt, 8'd1);
      drop_req(1'b0);
      tick();
      read_chk(1'b0, 8'd0, 8'h11, "t2_rd0");
      read_chk(1'b1, 8'd2, 8'h22, "t2_rd2");

      // 3: write to read-only address is blocked
      write_chk(1'b1, 8'd5, 8'hFF, 1'b1, "t3_wr");
      read_chk(1'b1, 8'd5, 8'h3C, "t3_rd");

      // 4: unmapped address
      write_chk(1'b0, 8'h09, 8'h77, 1'b1, "t4_wr");
      read_chk(1'b0, 8'h09, 8'h00, "t4_rd");

      // 5: reset while in RD_ADDR
      set_req(1'b0, 1'b0, 8'd0, 8'h00);
      tick();
      check_val("t5_gnt", bus_if.aGnt, 8'd1);
      drop_req(1'b0);
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_gnt", bus_if.aGnt, 8'd0);
      check_val("t5_rst_regaddr", bus_if.regAddr, 8'h00);
      check_val("t5_rst_ardata", bus_if.aRdata, 8'h00);
      tick();
      rst_n = 1'b1;
      seen_rv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus_if.aRvalid) seen_rv = 1'b1;
      end
      check_val("t5_no_rvalid", {7'd0, seen_rv}, 8'd0);
      read_chk(1'b0, 8'd0, 8'h11, "t5_rd");

      // 6: back-to-back reads with aReq held
      write_chk(1'b0, 8'd3, 8'h77, 1'b0, "t6_wr3");
      exp_b2b[0] = 8'h11; exp_b2b[1] = 8'h5A; exp_b2b[2] = 8'h22; exp_b2b[3] = 8'h77;
      set_req(1'b0, 1'b0, 8'd0, 8'h00);
      tick();
      check_val("t6_gnt0", bus_if.aGnt, 8'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) bus_if.aAddr = 8'(i + 1);
         else       bus_if.aReq  = 1'b0;
         tick();
         check_val($sformatf("t6_gap%0d", i), bus_if.aGnt, 8'd0);
         tick();
         tick();
         check_val($sformatf("t6_rv%0d", i), bus_if.aRvalid, 8'd1);
         check_val($sformatf("t6_rd%0d", i), bus_if.aRdata, exp_b2b[i]);
         check_val($sformatf("t6_gnt%0d", i + 1), bus_if.aGnt, {7'd0, i < 3});
      end
      tick();
      check_val("t6_idle_we", bus_if.regWriteEn, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
